// File: rtl/game_of_life_engine_pkg.sv
// game_of_life_engine_pkg: shared FSM state type and default Conway rule masks
package game_of_life_engine_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [8:0] CONWAY_BIRTH   = 9'h008;
   localparam logic [8:0] CONWAY_SURVIVE = 9'h00C;
endpackage

// File: rtl/game_of_life_engine_row_update.sv
// life_row_update: combinational next-state of one grid row from its two neighbour rows
module life_row_update
   import game_of_life_engine_pkg::*;
#(
   parameter int COLS = 16
) (
   input  logic [COLS-1:0] above,
   input  logic [COLS-1:0] cur,
   input  logic [COLS-1:0] below,
   input  logic            wrap,
   input  logic [8:0]      birth_mask,
   input  logic [8:0]      survive_mask,
   output logic [COLS-1:0] next_row
);
   logic [COLS+1:0] pa, pc, pb;
   assign pa = {wrap & above[0], above, wrap & above[COLS-1]};
   assign pc = {wrap & cur[0], cur, wrap & cur[COLS-1]};
   assign pb = {wrap & below[0], below, wrap & below[COLS-1]};
   for (genvar c = 0; c < COLS; c++) begin : g_cell
      logic [3:0] n;
      assign n = 4'(pa[c]) + 4'(pa[c+1]) + 4'(pa[c+2]) + 4'(pc[c]) + 4'(pc[c+2])
               + 4'(pb[c]) + 4'(pb[c+1]) + 4'(pb[c+2]);
      assign next_row[c] = pc[c+1] ? survive_mask[n] : birth_mask[n];
   end
endmodule

// File: rtl/game_of_life_engine.sv
// game_of_life_engine: row-sequential cellular automaton engine with shadow-buffered commits
module game_of_life_engine
   import game_of_life_engine_pkg::*;
#(
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int GEN_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [ROWS*COLS-1:0] data,
   input  logic                 start,
   input  logic [GEN_W-1:0]     num_gens,
   input  logic                 wrap,
   input  logic [8:0]           birth_mask,
   input  logic [8:0]           survive_mask,
   output logic [ROWS*COLS-1:0] grid,
   output logic                 busy,
   output logic                 done,
   output logic [GEN_W-1:0]     gen_count,
   output logic                 stable,
   output logic                 extinct
);
   localparam int N  = ROWS * COLS;
   localparam int RW = $clog2(ROWS);
   state_t              state, state_d;
   logic [RW-1:0]       row, row_up, row_dn;
   logic [N-1:0]        shadow, new_grid;
   logic [GEN_W-1:0]    gens_q, gen_next;
   logic                wrap_q, last_row, new_stable, new_extinct, stop;
   logic [8:0]          birth_q, survive_q;
   logic [COLS-1:0]     above, cur, below, new_row;
   assign last_row = row == RW'(ROWS-1);
   assign row_up   = row == '0 ? RW'(ROWS-1) : row - 1'b1;
   assign row_dn   = last_row ? '0 : row + 1'b1;
   assign busy     = state == RUN;
   assign done     = state == DONE;
   // neighbour rows come only from the committed grid; edge rows read as dead without wrap
   always_comb begin
      cur         = grid[int'(row)*COLS +: COLS];
      above       = (row == '0 && !wrap_q) ? '0 : grid[int'(row_up)*COLS +: COLS];
      below       = (last_row && !wrap_q) ? '0 : grid[int'(row_dn)*COLS +: COLS];
      new_grid    = shadow;
      new_grid[(ROWS-1)*COLS +: COLS] = new_row;
      gen_next    = gen_count + 1'b1;
      new_stable  = new_grid == grid;
      new_extinct = new_grid == '0;
      stop        = gen_next == gens_q || new_stable || new_extinct;
   end
   life_row_update #(.COLS(COLS)) u_row (
      .above       (above),
      .cur         (cur),
      .below       (below),
      .wrap        (wrap_q),
      .birth_mask  (birth_q),
      .survive_mask(survive_q),
      .next_row    (new_row)
   );
   // next-state: load beats start, zero-length runs skip straight to DONE
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = (!load && start) ? (num_gens == '0 ? DONE : RUN) : IDLE;
         RUN:     state_d = (last_row && stop) ? DONE : RUN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end
   // grid, shadow buffer, run parameters and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grid      <= '0;
         shadow    <= '0;
         row       <= '0;
         gen_count <= '0;
         stable    <= 1'b0;
         extinct   <= 1'b0;
         gens_q    <= '0;
         wrap_q    <= 1'b0;
         birth_q   <= '0;
         survive_q <= '0;
      end else if (state == IDLE) begin
         if (load) grid <= data;
         else if (start) begin
            gens_q    <= num_gens;
            wrap_q    <= wrap;
            birth_q   <= birth_mask;
            survive_q <= survive_mask;
            row       <= '0;
            if (num_gens != '0) begin
               gen_count <= '0;
               stable    <= 1'b0;
               extinct   <= 1'b0;
            end
         end
      end else if (state == RUN) begin
         shadow[int'(row)*COLS +: COLS] <= new_row;
         row <= row_dn;
         if (last_row) begin
            grid      <= new_grid;
            gen_count <= gen_next;
            stable    <= new_stable;
            extinct   <= new_extinct;
         end
      end
   end
endmodule

// File: tb/tb_game_of_life_engine.sv
// tb_game_of_life_engine: directed and randomized checks against a cell-by-cell life model
module tb_game_of_life_engine;
   import game_of_life_engine_pkg::*;
   localparam int R = 16;
   localparam int C = 16;
   localparam int N = R * C;
   logic          clk, reset, load, start, wrap;
   logic [N-1:0]  data, grid;
   logic [15:0]   num_gens, gen_count;
   logic [8:0]    birth_mask, survive_mask;
   logic          busy, done, stable, extinct;
   int            passed = 0, total = 0;

   game_of_life_engine dut (
      .clk(clk), .reset(reset), .load(load), .data(data), .start(start),
      .num_gens(num_gens), .wrap(wrap), .birth_mask(birth_mask), .survive_mask(survive_mask),
      .grid(grid), .busy(busy), .done(done), .gen_count(gen_count),
      .stable(stable), .extinct(extinct)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N-1:0] life_step(input logic [N-1:0] g, input bit w,
                                             input logic [8:0] b, input logic [8:0] s);
      logic [N-1:0] r;
      int n, rr, cc;
      r = '0;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) begin
            n = 0;
            for (int di = -1; di <= 1; di++)
               for (int dj = -1; dj <= 1; dj++) begin
                  if (di == 0 && dj == 0) continue;
                  rr = i + di;
                  cc = j + dj;
                  if (w) begin
                     rr = (rr + R) % R;
                     cc = (cc + C) % C;
                  end
                  if (rr >= 0 && rr < R && cc >= 0 && cc < C) n += int'(g[rr*C+cc]);
               end
            r[i*C+j] = g[i*C+j] ? s[n] : b[n];
         end
      return r;
   endfunction

   task automatic model_run(input logic [N-1:0] g0, input int n, input bit w,
                            input logic [8:0] b, input logic [8:0] s,
                            output logic [N-1:0] fg, output int gens, output bit st, output bit ex);
      logic [N-1:0] g, ng;
      g = g0;
      gens = 0;
      st = 0;
      ex = 0;
      while (1) begin
         ng = life_step(g, w, b, s);
         gens++;
         st = ng == g;
         ex = ng == '0;
         g = ng;
         if (gens == n || st || ex) break;
      end
      fg = g;
   endtask

   function automatic logic [N-1:0] rand_grid();
      logic [N-1:0] r;
      for (int k = 0; k < N / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [N-1:0] glider();
      logic [N-1:0] p;
      p = '0;
      p[1*C+2] = 1'b1;
      p[2*C+3] = 1'b1;
      p[3*C+1] = 1'b1;
      p[3*C+2] = 1'b1;
      p[3*C+3] = 1'b1;
      return p;
   endfunction

   task automatic do_load(input logic [N-1:0] d);
      @(negedge clk);
      load = 1'b1;
      data = d;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic start_run(input logic [15:0] n, input bit w, input logic [8:0] b, input logic [8:0] s);
      @(negedge clk);
      start = 1'b1;
      num_gens = n;
      wrap = w;
      birth_mask = b;
      survive_mask = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input bit perturb, output int cyc);
      cyc = 0;
      while (!done && cyc < bound) begin
         if (perturb) begin
            load = 1'($urandom);
            start = 1'($urandom);
            data = rand_grid();
            wrap = 1'($urandom);
            birth_mask = 9'($urandom);
            survive_mask = 9'($urandom);
            num_gens = 16'($urandom_range(0, 3));
         end
         @(negedge clk);
         cyc++;
      end
      load = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load = 1'b0;
      start = 1'b0;
      data = '0;
      num_gens = '0;
      wrap = 1'b0;
      birth_mask = CONWAY_BIRTH;
      survive_mask = CONWAY_SURVIVE;
      repeat (2) @(negedge clk);
      total++; if (grid !== '0) $display("FAIL reset_grid got %h want 0", grid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      total++; if (gen_count !== '0) $display("FAIL reset_gen_count got %0d want 0", gen_count); else passed++;
      total++; if (stable !== 1'b0) $display("FAIL reset_stable got %b want 0", stable); else passed++;
      total++; if (extinct !== 1'b0) $display("FAIL reset_extinct got %b want 0", extinct); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_blinker();
      logic [N-1:0] p;
      int cyc;
      p = '0;
      p[7*C+6] = 1'b1;
      p[7*C+7] = 1'b1;
      p[7*C+8] = 1'b1;
      do_load(p);
      start_run(2, 0, CONWAY_BIRTH, CONWAY_SURVIVE);
      total++; if (busy !== 1'b1) $display("FAIL blinker_busy got %b want 1", busy); else passed++;
      wait_done(200, 0, cyc);
      total++; if (cyc !== 32) $display("FAIL blinker_cycles got %0d want 32", cyc); else passed++;
      total++; if (gen_count !== 16'd2) $display("FAIL blinker_gen_count got %0d want 2", gen_count); else passed++;
      total++; if (grid !== p) $display("FAIL blinker_grid got %h want %h", grid, p); else passed++;
      total++; if (stable !== 1'b0) $display("FAIL blinker_stable got %b want 0", stable); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL blinker_done_pulse got %b want 0", done); else passed++;
   endtask

   task automatic test_block_and_zero_gens();
      logic [N-1:0] p;
      int cyc;
      p = '0;
      p[4*C+4] = 1'b1;
      p[4*C+5] = 1'b1;
      p[5*C+4] = 1'b1;
      p[5*C+5] = 1'b1;
      do_load(p);
      start_run(10, 0, CONWAY_BIRTH, CONWAY_SURVIVE);
      wait_done(400, 0, cyc);
      total++; if (cyc !== 16) $display("FAIL block_cycles got %0d want 16", cyc); else passed++;
      total++; if (gen_count !== 16'd1) $display("FAIL block_gen_count got %0d want 1", gen_count); else passed++;
      total++; if (stable !== 1'b1) $display("FAIL block_stable got %b want 1", stable); else passed++;
      total++; if (grid !== p) $display("FAIL block_grid got %h want %h", grid, p); else passed++;
      @(negedge clk);
      start_run(0, 0, CONWAY_BIRTH, CONWAY_SURVIVE);
      total++; if (done !== 1'b1) $display("FAIL zero_gens_done got %b want 1", done); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL zero_gens_busy got %b want 0", busy); else passed++;
      total++; if (grid !== p) $display("FAIL zero_gens_grid got %h want %h", grid, p); else passed++;
      total++; if (gen_count !== 16'd1) $display("FAIL zero_gens_gen_count got %0d want 1", gen_count); else passed++;
      @(negedge clk);
   endtask

   task automatic test_single_cell();
      logic [N-1:0] p;
      int cyc;
      p = '0;
      p[9*C+3] = 1'b1;
      do_load(p);
      start_run(5, 1, CONWAY_BIRTH, CONWAY_SURVIVE);
      wait_done(400, 0, cyc);
      total++; if (extinct !== 1'b1) $display("FAIL single_extinct got %b want 1", extinct); else passed++;
      total++; if (gen_count !== 16'd1) $display("FAIL single_gen_count got %0d want 1", gen_count); else passed++;
      total++; if (grid !== '0) $display("FAIL single_grid got %h want 0", grid); else passed++;
      @(negedge clk);
   endtask

   task automatic test_glider();
      logic [N-1:0] p, fg;
      int cyc, gens;
      bit st, ex;
      p = glider();
      do_load(p);
      start_run(64, 1, CONWAY_BIRTH, CONWAY_SURVIVE);
      wait_done(2000, 0, cyc);
      total++; if (grid !== p) $display("FAIL glider_wrap_grid got %h want %h", grid, p); else passed++;
      total++; if (gen_count !== 16'd64) $display("FAIL glider_wrap_gen_count got %0d want 64", gen_count); else passed++;
      total++; if (cyc !== 1024) $display("FAIL glider_wrap_cycles got %0d want 1024", cyc); else passed++;
      @(negedge clk);
      do_load(p);
      model_run(p, 64, 0, CONWAY_BIRTH, CONWAY_SURVIVE, fg, gens, st, ex);
      start_run(64, 0, CONWAY_BIRTH, CONWAY_SURVIVE);
      wait_done(2000, 0, cyc);
      total++; if (stable !== 1'b1) $display("FAIL glider_nowrap_stable got %b want 1", stable); else passed++;
      total++; if (grid !== fg) $display("FAIL glider_nowrap_grid got %h want %h", grid, fg); else passed++;
      total++; if (gen_count !== 16'(gens) || gens >= 64) $display("FAIL glider_nowrap_gen_count got %0d want %0d", gen_count, gens); else passed++;
      @(negedge clk);
   endtask

   task automatic test_load_start();
      logic [N-1:0] p;
      p = rand_grid();
      @(negedge clk);
      load = 1'b1;
      start = 1'b1;
      data = p;
      num_gens = 16'd4;
      @(negedge clk);
      load = 1'b0;
      start = 1'b0;
      total++; if (grid !== p) $display("FAIL load_start_grid got %h want %h", grid, p); else passed++;
      total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL load_start_idle got busy=%b done=%b want 0/0", busy, done); else passed++;
      @(negedge clk);
      total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL load_start_idle2 got busy=%b done=%b want 0/0", busy, done); else passed++;
   endtask

   task automatic test_random();
      logic [N-1:0] p, fg;
      logic [8:0] b, s;
      int cyc, gens, n;
      bit st, ex, w;
      for (int t = 0; t < 6; t++) begin
         p = rand_grid();
         w = 1'($urandom);
         n = $urandom_range(1, 5);
         b = (t % 2 == 0) ? CONWAY_BIRTH : 9'($urandom);
         s = (t % 2 == 0) ? CONWAY_SURVIVE : 9'($urandom);
         do_load(p);
         model_run(p, n, w, b, s, fg, gens, st, ex);
         start_run(16'(n), w, b, s);
         wait_done(200, 1, cyc);
         total++; if (cyc !== gens * 16) $display("FAIL rand%0d_cycles got %0d want %0d", t, cyc, gens * 16); else passed++;
         total++; if (grid !== fg) $display("FAIL rand%0d_grid got %h want %h", t, grid, fg); else passed++;
         total++; if (gen_count !== 16'(gens)) $display("FAIL rand%0d_gen_count got %0d want %0d", t, gen_count, gens); else passed++;
         total++; if (stable !== st) $display("FAIL rand%0d_stable got %b want %b", t, stable, st); else passed++;
         total++; if (extinct !== ex) $display("FAIL rand%0d_extinct got %b want %b", t, extinct, ex); else passed++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midrun();
      bit saw;
      do_load(glider());
      start_run(64, 1, CONWAY_BIRTH, CONWAY_SURVIVE);
      repeat (37) @(negedge clk);
      total++; if (busy !== 1'b1 || gen_count !== 16'd2) $display("FAIL midrun_state got busy=%b gen=%0d want 1/2", busy, gen_count); else passed++;
      #2 reset = 1'b1;
      #1;
      total++; if (grid !== '0) $display("FAIL midrun_reset_grid got %h want 0", grid); else passed++;
      total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrun_reset_flags got busy=%b done=%b want 0/0", busy, done); else passed++;
      total++; if (gen_count !== '0 || stable !== 1'b0 || extinct !== 1'b0) $display("FAIL midrun_reset_status got gen=%0d st=%b ex=%b want 0/0/0", gen_count, stable, extinct); else passed++;
      @(negedge clk);
      reset = 1'b0;
      saw = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) saw = 1;
      end
      total++; if (saw !== 1'b0) $display("FAIL midrun_after_reset got activity=%b want 0", saw); else passed++;
      total++; if (grid !== '0) $display("FAIL midrun_after_grid got %h want 0", grid); else passed++;
   endtask

   initial begin
      test_reset();
      test_blinker();
      test_block_and_zero_gens();
      test_single_cell();
      test_glider();
      test_load_start();
      test_random();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/game_of_life_engine.md
GAME_OF_LIFE_ENGINE -- requirements
Module: game_of_life_engine

Interface
REQ-001 SHALL provide parameter ROWS, default 16, grid height in cells (>=3).
REQ-002 SHALL provide parameter COLS, default 16, grid width in cells (>=3).
REQ-003 SHALL provide parameter GEN_W, default 16, width of generation counters.
REQ-004 SHALL provide ports: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide: load  input  1  load data into grid (idle only).
REQ-007 SHALL provide: data  input  ROWS*COLS  grid image; cell (r,c) = bit r*COLS+c, row 0 first.
REQ-008 SHALL provide: start  input  1  begin a run of num_gens generations.
REQ-009 SHALL provide: num_gens  input  GEN_W  generations to compute in the run.
REQ-010 SHALL provide: wrap  input  1  1 = toroidal edges, 0 = out-of-grid neighbours dead.
REQ-011 SHALL provide: birth_mask  input  9  bit n set = dead cell with n live neighbours becomes alive.
REQ-012 SHALL provide: survive_mask  input  9  bit n set = live cell with n live neighbours stays alive.
REQ-013 SHALL provide: grid  output  ROWS*COLS  current generation, same bit mapping as data.
REQ-014 SHALL provide: busy  output  1  high in RUN state.
REQ-015 SHALL provide: done  output  1  one-cycle pulse at end of run.
REQ-016 SHALL provide: gen_count  output  GEN_W  generations committed in current/last run.
REQ-017 SHALL provide: stable  output  1  last commit equalled previous grid.
REQ-018 SHALL provide: extinct  output  1  last commit was all-dead.

Function
REQ-019 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; DONE lasts exactly one cycle with done=1.
REQ-020 In IDLE, load=1 SHALL write data to grid next edge; load takes priority over simultaneous start (start dropped).
REQ-021 start in IDLE (load=0) SHALL latch num_gens, wrap, birth_mask, survive_mask; clear gen_count, stable, extinct; enter RUN.
REQ-022 start with num_gens=0 SHALL go IDLE -> DONE directly; grid and gen_count unchanged.
REQ-023 RUN SHALL sweep one row per cycle, rows 0..ROWS-1, reading only the committed grid; next row values held in a shadow buffer.
REQ-024 Neighbour count n (0..8) SHALL be the 8-neighbour sum, 4-bit; next cell = alive ? survive_mask[n] : birth_mask[n].
REQ-025 wrap=1: row/col indices SHALL wrap modulo ROWS/COLS; wrap=0: any neighbour outside grid SHALL count 0.
REQ-026 On the row ROWS-1 cycle, grid SHALL take the full new generation (shadow + last row) on that edge; gen_count increments by 1; one generation = ROWS cycles.
REQ-027 On each commit stable SHALL = (new grid == old grid); extinct SHALL = (new grid == 0).
REQ-028 After a commit, RUN SHALL go to DONE if gen_count equals latched num_gens or stable=1 or extinct=1; else restart at row 0 next cycle.
REQ-029 load and start SHALL be ignored while busy or in DONE; input changes mid-run SHALL not affect the run.
REQ-030 gen_count, stable, extinct SHALL hold after DONE until next accepted start or reset.

Reset
REQ-031 reset SHALL asynchronously force: grid=0, state IDLE, row index 0, shadow buffer 0, gen_count=0, busy=0, done=0, stable=0, extinct=0.
REQ-032 reset mid-run SHALL abandon the run with no partial commit after deassertion; no done pulse.

Structure
REQ-033 Shared package SHALL hold FSM state typedef (IDLE/RUN/DONE) and the Conway masks B3/S23 (birth 9'h008, survive 9'h00C).
REQ-034 One sub-module life_row_update SHALL compute one row's next state from three rows, wrap and masks (combinational, COLS-parameterised).

Verification
REQ-035 Blinker (rows 7, cols 6-8) 16x16, Conway, wrap=0, num_gens=2 -> done 32 cycles after RUN entry, gen_count=2, grid = original, stable=0.
REQ-036 2x2 block, num_gens=10 -> done after 1 generation, gen_count=1, stable=1, grid unchanged.
REQ-037 Single live cell, Conway, num_gens=5 -> extinct=1, gen_count=1, grid=0.
REQ-038 Glider, wrap=1, num_gens=64 on 16x16 -> grid equals initial pattern, gen_count=64; same with wrap=0 -> glider becomes block, run stops early with stable=1.
REQ-039 start with num_gens=0 -> done next-but-one cycle, grid unchanged; load+start same cycle -> grid=data, no run.
REQ-040 reset asserted mid-run (row 5 of gen 3) -> all outputs reset values immediately, no done pulse, IDLE afterwards.
